// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO block family (fifo_cnt and fifo_unpacker).
package fifo_pkg;

    // Default FIFO word width shared by the FIFO and its drain stages.
    localparam int FIFO_DATA_WIDTH = 32;

    // Unpacker control state: IDLE = no word held, BUSY = word held with lanes pending.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } unpack_state_e;

    // Number of output lanes carved out of one FIFO word.
    function automatic int lane_ratio(input int dw, input int ow);
        return dw / ow;
    endfunction

endpackage

// File: rtl/fifo_lane_sel.sv
// Pure combinational lane selector: picks lane idx_i out of word_i.
// MSB_FIRST=1 makes lane 0 the top slice of the word, MSB_FIRST=0 the bottom slice.
module fifo_lane_sel
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH  = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDX_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [OUT_WIDTH-1:0]  lane_o
);

    localparam int RATIO = lane_ratio(DATA_WIDTH, OUT_WIDTH);

    // One-hot compare per lane; indices beyond RATIO-1 select zero.
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_i == IDX_W'(i)) begin
                if (MSB_FIRST != 0) begin
                    lane_o = word_i[DATA_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
                end else begin
                    lane_o = word_i[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_unpacker.sv
// FWFT FIFO drain stage: pops DATA_WIDTH words and streams them out as
// OUT_WIDTH lanes, one lane per cycle, back-to-back words without bubbles.
// Optional feature: define FIFO_UNPACKER_STAT_EN to add the saturating
// output-lane counter port lane_cnt.
module fifo_unpacker
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH  = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef FIFO_UNPACKER_STAT_EN
    ,
    output logic [31:0]           lane_cnt
`endif
);

    localparam int RATIO = lane_ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
            $error("fifo_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 lanes");
        end
    endgenerate

    unpack_state_e         state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  valid_q;
    logic                  last_lane;
    logic                  hshake;

    assign last_lane = (idx_q == IDX_W'(RATIO - 1));
    assign hshake    = valid_q && m_ready;

    // Pop when nothing is held, or when the final lane is consumed this cycle
    // so the next word loads without a bubble. Reset blocks any pop.
    assign fifo_ren = !rst && !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == BUSY) && hshake && last_lane));

    // Control FSM: load word on pop, step through lanes on handshake, go idle when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else if (fifo_ren) begin
            state_q <= BUSY;
            valid_q <= 1'b1;
            idx_q   <= '0;
            hold_q  <= fifo_dout;
        end else if ((state_q == BUSY) && hshake) begin
            if (last_lane) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    fifo_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .IDX_W      (IDX_W)
    ) u_lane_sel (
        .word_i (hold_q),
        .idx_i  (idx_q),
        .lane_o (m_data)
    );

    assign m_valid = valid_q;
    assign m_last  = valid_q && last_lane;

`ifdef FIFO_UNPACKER_STAT_EN
    logic [31:0] lane_cnt_q;
    logic [31:0] lane_cnt_d;

    // Next count: +1 per output handshake, sticks at all-ones instead of wrapping.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        if (hshake && (lane_cnt_q != 32'hFFFF_FFFF)) begin
            lane_cnt_d = lane_cnt_q + 32'd1;
        end
    end

    // Lane counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt_q <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
        end
    end

    assign lane_cnt = lane_cnt_q;
`endif

endmodule
